uart_tx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_bit_tick.sv | 34 +++
 rtl/uart_tx_frame.sv | 140 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants: framer state encoding, line levels, tick-counter sizing.
// No logic of its own; imported by the TX framer and its bit-tick counter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;

   function automatic int unsigned tick_w(input int unsigned os);
      return (os < 2) ? 1 : $clog2(os);
   endfunction

endpackage

// File: rtl/uart_bit_tick.sv
// Oversample tick counter: counts 0..OVERSAMPLE-1 while enabled, bit_end_o marks the last cycle of a bit.
// Single-cycle decode of the registered count; clear_i has priority and never stalls.
module uart_bit_tick #(
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic baud_clk,
   input  logic clear_i,
   input  logic en_i,
   output logic bit_end_o
);
   import uart_pkg::*;

   localparam int unsigned  W    = tick_w(OVERSAMPLE);
   localparam logic [W-1:0] LAST = W'(OVERSAMPLE - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge baud_clk) begin
      cnt_q <= cnt_d;
   end

   // Kept independent of clear_i: the framer derives clear_i from this signal.
   assign bit_end_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART TX framer: start, DATA_BITS LSB-first, optional parity (UART_TX_PARITY_EN), STOP_BITS stops; line falls 1 cycle after accept.
// Ready only in IDLE with rst low; requests while busy are dropped, no queuing.
module uart_tx_frame #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                 baud_clk,
   input  logic                 rst,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx_out,
   output logic                 tx_busy,
   output logic                 tx_done
);
   import uart_pkg::*;

   localparam int unsigned   BW        = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 2 ||
       STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_cfg
      $error("uart_tx_frame: illegal parameter set");
   end

   tx_state_t            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [BW-1:0]        idx_q, idx_d;
   logic                 out_q, out_d;
   logic                 bit_end, accept;

   assign tx_ready = (state_q == IDLE) && !rst;
   assign accept   = tx_valid && tx_ready;
   assign tx_busy  = (state_q != IDLE);
   assign tx_out   = out_q;
   assign tx_done  = (state_q == STOP) && bit_end && (idx_q == LAST_STOP) && !rst;

`ifdef UART_TX_PARITY_EN
   localparam logic ODD = (PARITY_ODD != 0);
   logic parity_q;

   always_ff @(posedge baud_clk) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else if (accept) begin
         parity_q <= (^tx_data) ^ ODD;
      end
   end
`endif

   // The line level is decided from the next state so tx_out leaves a flop in step with state_q.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      out_d   = out_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = START;
               shift_d = tx_data;
               out_d   = LINE_START;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               out_d   = shift_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx_q == LAST_DATA) begin
                  idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  out_d   = parity_q;
`else
                  state_d = STOP;
                  out_d   = LINE_IDLE;
`endif
               end else begin
                  idx_d   = idx_q + 1'b1;
                  shift_d = shift_q >> 1;
                  out_d   = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               out_d   = LINE_IDLE;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               if (idx_q == LAST_STOP) begin
                  state_d = IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            out_d   = LINE_IDLE;
         end
      endcase
   end

   always_ff @(posedge baud_clk) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         out_q   <= LINE_IDLE;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         out_q   <= out_d;
      end
   end

   uart_bit_tick #(
      .OVERSAMPLE(OVERSAMPLE)
   ) u_tick (
      .baud_clk (baud_clk),
      .clear_i  (rst || (state_d != state_q)),
      .en_i     (state_q != IDLE),
      .bit_end_o(bit_end)
   );

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations checked every cycle against a frame-position model,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int NI = 3;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst [NI];
   logic       vld [NI];
   logic [7:0] dat [NI];
   logic       rdy [NI];
   logic       txo [NI];
   logic       bsy [NI];
   logic       dn  [NI];

   uart_tx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
      .baud_clk(clk), .rst(rst[0]), .tx_valid(vld[0]), .tx_data(dat[0]),
      .tx_ready(rdy[0]), .tx_out(txo[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));
   uart_tx_frame #(.DATA_BITS(8), .OVERSAMPLE(4), .STOP_BITS(2), .PARITY_ODD(0)) u1 (
      .baud_clk(clk), .rst(rst[1]), .tx_valid(vld[1]), .tx_data(dat[1]),
      .tx_ready(rdy[1]), .tx_out(txo[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));
   uart_tx_frame #(.DATA_BITS(8), .OVERSAMPLE(4), .STOP_BITS(1), .PARITY_ODD(1)) u2 (
      .baud_clk(clk), .rst(rst[2]), .tx_valid(vld[2]), .tx_data(dat[2]),
      .tx_ready(rdy[2]), .tx_out(txo[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));

   function automatic int os_of(input int i);
      return (i == 0) ? 16 : 4;
   endfunction
   function automatic int sb_of(input int i);
      return (i == 1) ? 2 : 1;
   endfunction
   function automatic logic odd_of(input int i);
      return (i == 2);
   endfunction
   function automatic int fl(input int i);
      return (1 + 8 + P + sb_of(i)) * os_of(i);
   endfunction

   // Line level k cycles into a frame: bit slot k/OS of [start, d0..d7, parity?, stops].
   function automatic logic exp_bit(input int i, input int k, input logic [7:0] d);
      int b;
      b = k / os_of(i);
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if (P == 1 && b == 9) return (^d) ^ odd_of(i);
      return 1'b1;
   endfunction

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, i, $time, act, exp);
   endtask

   // Reference model: frame active flag, position within frame, captured byte.
   bit         m_act [NI];
   int         m_k   [NI];
   logic [7:0] m_d   [NI];
   bit         cmp_en = 1'b0;

   always @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (rst[i]) begin
            m_act[i] <= 1'b0;
         end else if (m_act[i]) begin
            if (m_k[i] + 1 >= fl(i)) m_act[i] <= 1'b0;
            m_k[i] <= m_k[i] + 1;
         end else if (vld[i]) begin
            m_act[i] <= 1'b1;
            m_k[i]   <= 0;
            m_d[i]   <= dat[i];
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int i = 0; i < NI; i++) begin
            chk("tx_out", i, txo[i], m_act[i] ? exp_bit(i, m_k[i], m_d[i]) : 1'b1);
            chk("tx_busy", i, bsy[i], m_act[i]);
            chk("tx_done", i, dn[i], m_act[i] && (m_k[i] == fl(i) - 1) && !rst[i]);
            chk("tx_ready", i, rdy[i], !m_act[i] && !rst[i]);
         end
      end
   end

   logic tr_out  [0:255];
   logic tr_done [0:255];
   logic tr_rdy  [0:255];
   logic tr_busy [0:255];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int i, input logic [7:0] d);
      vld[i] = 1'b1;
      dat[i] = d;
      tick();
      vld[i] = 1'b0;
   endtask

   // Called just after the acceptance edge: slot c holds "cycle c" of the frame.
   task automatic record(input int i, input int n);
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         tr_out[c]  = txo[i];
         tr_done[c] = dn[i];
         tr_rdy[c]  = rdy[i];
         tr_busy[c] = bsy[i];
      end
      tick();
   endtask

   function automatic int first_done(input int n);
      for (int c = 1; c <= n; c++) if (tr_done[c] === 1'b1) return c;
      return 0;
   endfunction

   function automatic int count_ones(input int lo, input int hi);
      int s = 0;
      for (int c = lo; c <= hi; c++) if (tr_out[c] === 1'b1) s++;
      return s;
   endfunction

   task automatic wait_idle(input int i);
      int n = 0;
      while (bsy[i] !== 1'b0 && n < 400) begin
         tick();
         n++;
      end
      chk("idle_wait", i, bsy[i], 1'b0);
   endtask

   initial begin
      logic [7:0] g;
      int dc;
      #200000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] g;
      int dc;
      for (int i = 0; i < NI; i++) begin
         rst[i] = 1'b1;
         vld[i] = 1'b0;
         dat[i] = 8'h00;
      end
      tick();
      cmp_en = 1'b1;
      tick();
      @(negedge clk);
      chk("rst_ready", 0, rdy[0], 1'b0);
      chk("rst_out", 0, txo[0], 1'b1);
      chk("rst_busy", 0, bsy[0], 1'b0);
      chk("rst_done", 0, dn[0], 1'b0);
      tick();
      for (int i = 0; i < NI; i++) rst[i] = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 0, rdy[0], 1'b1);
      tick();

      // Basic frame, 0xA5 at OVERSAMPLE 16
      send(0, 8'hA5);
      record(0, 180);
      chk("t1_start_low", 0, 16 - count_ones(1, 16), 16);
      for (int b = 0; b < 8; b++) g[b] = tr_out[17 + 16 * b];
      chk("t1_data", 0, g, 8'hA5);
      chk("t1_bit145", 0, tr_out[145], (P == 1) ? 1'b0 : 1'b1);
      dc = first_done(180);
      chk("t1_done_cycle", 0, dc, (P == 1) ? 176 : 160);
      chk("t1_ready_on_done", 0, tr_rdy[dc], 1'b0);
      chk("t1_ready_after", 0, tr_rdy[dc + 1], 1'b1);

      // Odd-parity configuration, 0xA5 (four ones -> odd parity bit 1)
      send(2, 8'hA5);
      record(2, 60);
      chk("t2_bit37", 2, tr_out[37], 1'b1);
      chk("t2_done_cycle", 2, first_done(60), (P == 1) ? 44 : 40);

      // Two stop bits at OVERSAMPLE 4, 0x01
      send(1, 8'h01);
      record(1, 60);
      dc = first_done(60);
      chk("t6_done_cycle", 1, dc, (P == 1) ? 48 : 44);
      chk("t6_stop_high", 1, count_ones(dc - 7, dc), 8);
      chk("t6_bit0", 1, count_ones(5, 8), 4);
      chk("t6_bit1", 1, tr_out[9], 1'b0);
      chk("t6_parity", 1, tr_out[37], 1'b1);

      // Back-to-back with tx_valid held, data changes mid-frame
      vld[1] = 1'b1;
      dat[1] = 8'h00;
      tick();
      dat[1] = 8'hFF;
      record(1, 100);
      dc = (P == 1) ? 48 : 44;
      chk("t3_done_cycle", 1, first_done(100), dc);
      chk("t3_first_data", 1, count_ones(5, 36), 0);
      chk("t3_gap_ready", 1, tr_rdy[dc + 1], 1'b1);
      chk("t3_second_busy", 1, tr_busy[dc + 2], 1'b1);
      chk("t3_second_data", 1, count_ones(dc + 6, dc + 37), 32);
      vld[1] = 1'b0;
      wait_idle(1);

      // Ignored request during DATA
      send(0, 8'hC3);
      repeat (40) tick();
      vld[0] = 1'b1;
      dat[0] = 8'h3C;
      tick();
      vld[0] = 1'b0;
      wait_idle(0);
      @(negedge clk);
      chk("t4_ready", 0, rdy[0], 1'b1);
      tick();

      // Reset during data bit 3, then a clean 0x5A
      send(0, 8'h96);
      repeat (69) tick();
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0;
      @(negedge clk);
      chk("t5_out", 0, txo[0], 1'b1);
      chk("t5_busy", 0, bsy[0], 1'b0);
      tick();
      send(0, 8'h5A);
      record(0, 180);
      for (int b = 0; b < 8; b++) g[b] = tr_out[17 + 16 * b];
      chk("t5_data", 0, g, 8'h5A);
      chk("t5_done_cycle", 0, first_done(180), (P == 1) ? 176 : 160);

      // Randomized traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NI; i++) begin
            rst[i] = ($urandom_range(0, 299) == 0);
            vld[i] = ($urandom_range(0, 5) == 0);
            dat[i] = 8'($urandom);
         end
         tick();
      end
      for (int i = 0; i < NI; i++) begin
         rst[i] = 1'b0;
         vld[i] = 1'b0;
      end
      repeat (200) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
